// File: rtl/life_pkg.sv
// Shared HUD package for the life-icon tracker: state type, coordinate width
// and the default icon geometry used by the tracker, the mux and other HUD blocks.
package life_pkg;

  typedef enum logic [1:0] {
    ALIVE,
    INVULN,
    DEAD
  } life_state_t;

  localparam int COORD_W = 11;

  localparam int DEF_MAX_LIVES  = 3;
  localparam int LIVES_W        = $clog2(DEF_MAX_LIVES + 1);

  localparam int DEF_ICON_W     = 72;
  localparam int DEF_ICON_H     = 72;
  localparam int DEF_ICON_GAP   = 8;
  localparam int DEF_TOP_LEFT_X = 16;
  localparam int DEF_TOP_LEFT_Y = 400;

  // Left edge of icon slot `slot` for a horizontal row of equally spaced icons.
  function automatic int slot_left_x(input int top_left_x, input int icon_w,
                                     input int icon_gap, input int slot);
    return top_left_x + slot * (icon_w + icon_gap);
  endfunction

endpackage

// File: rtl/life_icon_locator.sv
// Combinational slot lookup: one range comparator per icon slot, yields the
// inside flag and icon-relative offsets (zero when no drawn slot matches).
module life_icon_locator
  import life_pkg::*;
#(
  parameter int MAX_LIVES  = DEF_MAX_LIVES,
  parameter int LW         = LIVES_W,
  parameter int ICON_W     = DEF_ICON_W,
  parameter int ICON_H     = DEF_ICON_H,
  parameter int ICON_GAP   = DEF_ICON_GAP,
  parameter int TOP_LEFT_X = DEF_TOP_LEFT_X,
  parameter int TOP_LEFT_Y = DEF_TOP_LEFT_Y
) (
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic [LW-1:0]      lives,
  input  logic               blink_en,
  output logic               hit,
  output logic [COORD_W-1:0] offset_x,
  output logic [COORD_W-1:0] offset_y
);

  localparam logic [COORD_W:0] TOP_Y = (COORD_W + 1)'(TOP_LEFT_Y);
  localparam logic [COORD_W:0] BOT_Y = (COORD_W + 1)'(TOP_LEFT_Y + ICON_H);

  logic [COORD_W:0]   px;
  logic [COORD_W:0]   py;
  logic               y_in;
  logic [MAX_LIVES-1:0] slot_hit;
  logic [COORD_W-1:0] slot_left [MAX_LIVES];

  assign px   = {1'b0, pixel_x};
  assign py   = {1'b0, pixel_y};
  assign y_in = (py >= TOP_Y) && (py < BOT_Y);

  // The slot just lost (index == lives) is only shown while blinking is enabled.
  for (genvar g = 0; g < MAX_LIVES; g++) begin : g_slot
    localparam logic [COORD_W:0] LEFT =
      (COORD_W + 1)'(slot_left_x(TOP_LEFT_X, ICON_W, ICON_GAP, g));
    localparam logic [COORD_W:0] RIGHT =
      (COORD_W + 1)'(slot_left_x(TOP_LEFT_X, ICON_W, ICON_GAP, g) + ICON_W);

    logic drawn;

    assign drawn         = (int'(lives) > g) || (blink_en && (int'(lives) == g));
    assign slot_hit[g]   = y_in && (px >= LEFT) && (px < RIGHT) && drawn;
    assign slot_left[g]  = LEFT[COORD_W-1:0];
  end

  always_comb begin
    hit      = |slot_hit;
    offset_x = '0;
    offset_y = '0;
    for (int i = 0; i < MAX_LIVES; i++) begin
      if (slot_hit[i]) begin
        offset_x = pixel_x - slot_left[i];
      end
    end
    if (hit) begin
      offset_y = pixel_y - TOP_Y[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/life_icon_tracker.sv
// Lives/game-state tracker feeding the life-icon renderer with registered offsets.
// Optional LIFE_INVULN_EN adds post-hit invulnerability with a blinking lost icon.
module life_icon_tracker
  import life_pkg::*;
#(
  parameter int MAX_LIVES     = 3,
  parameter int INIT_LIVES    = 3,
  parameter int ICON_W        = 72,
  parameter int ICON_H        = 72,
  parameter int ICON_GAP      = 8,
  parameter int TOP_LEFT_X    = 16,
  parameter int TOP_LEFT_Y    = 400,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_PERIOD  = 8
) (
  input  logic                             clk,
  input  logic                             resetN,
  input  logic                             startOfFrame,
  input  logic [COORD_W-1:0]               pixelX,
  input  logic [COORD_W-1:0]               pixelY,
  input  logic                             playerHit,
  input  logic                             extraLife,
  input  logic                             newGame,
  output logic [COORD_W-1:0]               offsetX,
  output logic [COORD_W-1:0]               offsetY,
  output logic                             InsideRectangle,
  output logic [$clog2(MAX_LIVES+1)-1:0]   livesCount,
  output logic                             gameOver
);

  localparam int           LW     = $clog2(MAX_LIVES + 1);
  localparam logic [LW-1:0] INIT_L = LW'(INIT_LIVES);
  localparam logic [LW-1:0] MAX_L  = LW'(MAX_LIVES);
  localparam logic [LW-1:0] ONE_L  = LW'(1);

  if (INIT_LIVES > MAX_LIVES) begin : g_bad_init
    $error("INIT_LIVES must not exceed MAX_LIVES");
  end
  if ((BLINK_PERIOD < 1) || ((BLINK_PERIOD & (BLINK_PERIOD - 1)) != 0)) begin : g_bad_blink
    $error("BLINK_PERIOD must be a power of two");
  end
  if (INVULN_FRAMES < 1) begin : g_bad_frames
    $error("INVULN_FRAMES must be at least 1");
  end

  life_state_t        state_q, state_d;
  logic [LW-1:0]      lives_q, lives_d;
  logic               game_over_q, game_over_d;
  logic               inside_q, inside_d;
  logic [COORD_W-1:0] off_x_q, off_x_d;
  logic [COORD_W-1:0] off_y_q, off_y_d;

  logic               blink_en;
  logic               loc_hit;
  logic [COORD_W-1:0] loc_off_x;
  logic [COORD_W-1:0] loc_off_y;

`ifdef LIFE_INVULN_EN
  localparam int CNT_W     = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
  localparam int BLINK_BIT = $clog2(BLINK_PERIOD);

  if (BLINK_BIT >= CNT_W) begin : g_bad_blink_bit
    $error("BLINK_PERIOD too large for INVULN_FRAMES");
  end

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Lost icon is visible on even blink half-periods of the invulnerability window.
  assign blink_en = (state_q == INVULN) && !frame_cnt_q[BLINK_BIT];
`else
  logic unused_sof;

  assign unused_sof = startOfFrame;
  assign blink_en   = 1'b0;
`endif

  life_icon_locator #(
    .MAX_LIVES  (MAX_LIVES),
    .LW         (LW),
    .ICON_W     (ICON_W),
    .ICON_H     (ICON_H),
    .ICON_GAP   (ICON_GAP),
    .TOP_LEFT_X (TOP_LEFT_X),
    .TOP_LEFT_Y (TOP_LEFT_Y)
  ) u_locator (
    .pixel_x  (pixelX),
    .pixel_y  (pixelY),
    .lives    (lives_q),
    .blink_en (blink_en),
    .hit      (loc_hit),
    .offset_x (loc_off_x),
    .offset_y (loc_off_y)
  );

  // newGame beats everything; a hit in ALIVE swallows a same-cycle extraLife.
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
`ifdef LIFE_INVULN_EN
    frame_cnt_d = frame_cnt_q;
`endif
    if (newGame) begin
      state_d = ALIVE;
      lives_d = INIT_L;
`ifdef LIFE_INVULN_EN
      frame_cnt_d = '0;
`endif
    end else begin
      case (state_q)
        ALIVE: begin
          if (playerHit) begin
            if (lives_q != '0) begin
              lives_d = lives_q - ONE_L;
            end
            if (lives_q <= ONE_L) begin
              state_d = DEAD;
            end
`ifdef LIFE_INVULN_EN
            else begin
              state_d     = INVULN;
              frame_cnt_d = '0;
            end
`endif
          end else if (extraLife && (lives_q != MAX_L)) begin
            lives_d = lives_q + ONE_L;
          end
        end
`ifdef LIFE_INVULN_EN
        INVULN: begin
          if (extraLife && (lives_q != MAX_L)) begin
            lives_d = lives_q + ONE_L;
          end
          if (startOfFrame) begin
            if (frame_cnt_q == CNT_W'(INVULN_FRAMES - 1)) begin
              state_d     = ALIVE;
              frame_cnt_d = '0;
            end else begin
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
            end
          end
        end
`endif
        default: begin
        end
      endcase
    end

    game_over_d = (state_d == DEAD);
    inside_d    = loc_hit;
    off_x_d     = loc_off_x;
    off_y_d     = loc_off_y;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ALIVE;
      lives_q     <= INIT_L;
      game_over_q <= 1'b0;
      inside_q    <= 1'b0;
      off_x_q     <= '0;
      off_y_q     <= '0;
`ifdef LIFE_INVULN_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      inside_q    <= inside_d;
      off_x_q     <= off_x_d;
      off_y_q     <= off_y_d;
`ifdef LIFE_INVULN_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign offsetX         = off_x_q;
  assign offsetY         = off_y_q;
  assign InsideRectangle = inside_q;
  assign livesCount      = lives_q;
  assign gameOver        = game_over_q;

endmodule

// File: tb/tb_life_icon_tracker.sv
// Self-checking bench for life_icon_tracker: a frame/lives model derived from the
// icon layout rules, checked every cycle, plus pinned literal expectations.
module tb_life_icon_tracker;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = '0;
  logic [10:0] pixelY = '0;
  logic        playerHit = 1'b0;
  logic        extraLife = 1'b0;
  logic        newGame = 1'b0;
  logic [10:0] offsetX;
  logic [10:0] offsetY;
  logic        InsideRectangle;
  logic [1:0]  livesCount;
  logic        gameOver;

  int total = 0;
  int bad   = 0;

`ifdef LIFE_INVULN_EN
  localparam bit INVULN_EN = 1'b1;
`else
  localparam bit INVULN_EN = 1'b0;
`endif

  // model state: mode 0 = alive, 1 = invulnerable, 2 = dead
  int m_lives, m_mode, m_frames;
  int e_inside, e_off_x, e_off_y, e_lives, e_over;

  life_icon_tracker dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .playerHit       (playerHit),
    .extraLife       (extraLife),
    .newGame         (newGame),
    .offsetX         (offsetX),
    .offsetY         (offsetY),
    .InsideRectangle (InsideRectangle),
    .livesCount      (livesCount),
    .gameOver        (gameOver)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOne(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkLiteral(input string name, input int act, input int exp);
    checkOne(name, act, exp);
  endtask

  function automatic bit drawn(input int i);
    if (i < m_lives) return 1'b1;
    return (m_mode == 1) && (i == m_lives) && (((m_frames / 8) % 2) == 0);
  endfunction

  task automatic modelReset();
    m_lives = 3; m_mode = 0; m_frames = 0;
    e_inside = 0; e_off_x = 0; e_off_y = 0; e_lives = 3; e_over = 0;
  endtask

  task automatic modelStep(input int x, input int y, input bit hit, input bit xl,
                           input bit ng, input bit sof);
    int rel, slot, old_mode;
    e_inside = 0; e_off_x = 0; e_off_y = 0;
    if (y >= 400 && y < 472 && x >= 16) begin
      rel  = x - 16;
      slot = rel / 80;
      if (slot < 3 && (rel % 80) < 72 && drawn(slot)) begin
        e_inside = 1; e_off_x = rel % 80; e_off_y = y - 400;
      end
    end
    old_mode = m_mode;
    if (ng) begin
      m_lives = 3; m_mode = 0; m_frames = 0;
    end else if (old_mode != 2) begin
      if (hit && old_mode == 0) begin
        m_lives--;
        if (m_lives == 0) m_mode = 2;
        else if (INVULN_EN) begin m_mode = 1; m_frames = 0; end
      end else if (xl) begin
        m_lives = (m_lives < 3) ? m_lives + 1 : 3;
      end
      if (old_mode == 1 && sof) begin
        if (m_frames == 59) begin m_mode = 0; m_frames = 0; end
        else m_frames++;
      end
    end
    e_lives = m_lives;
    e_over  = (m_mode == 2) ? 1 : 0;
  endtask

  task automatic checkOutput();
    checkOne("inside", int'(InsideRectangle), e_inside);
    checkOne("offset_x", int'(offsetX), e_off_x);
    checkOne("offset_y", int'(offsetY), e_off_y);
    checkOne("lives", int'(livesCount), e_lives);
    checkOne("game_over", int'(gameOver), e_over);
  endtask

  task automatic applyStimulus(input int x, input int y, input bit hit, input bit xl,
                               input bit ng, input bit sof);
    @(negedge clk);
    pixelX = 11'(x); pixelY = 11'(y);
    playerHit = hit; extraLife = xl; newGame = ng; startOfFrame = sof;
    modelStep(x, y, hit, xl, ng, sof);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic runFrames(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(180, 400, 0, 0, 0, 1);
      applyStimulus(180, 400, 0, 0, 0, 0);
    end
  endtask

  int bx[10] = '{16, 87, 88, 15, 96, 247, 248, 256, 16, 176};
  int by[10] = '{400, 471, 400, 400, 400, 471, 400, 400, 399, 471};

  initial begin
    modelReset();
    #2 resetN = 1'b0;
    #1;
    checkLiteral("reset_lives", int'(livesCount), 3);
    checkLiteral("reset_inside", int'(InsideRectangle), 0);
    checkLiteral("reset_game_over", int'(gameOver), 0);
    checkLiteral("reset_offset_x", int'(offsetX), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;

    applyStimulus(100, 410, 0, 0, 0, 0);
    checkLiteral("lit_inside_100_410", int'(InsideRectangle), 1);
    checkLiteral("lit_offx_100_410", int'(offsetX), 4);
    checkLiteral("lit_offy_100_410", int'(offsetY), 10);
    checkLiteral("lit_lives_start", int'(livesCount), 3);

    applyStimulus(90, 410, 0, 0, 0, 0);
    checkLiteral("lit_gap_inside", int'(InsideRectangle), 0);
    checkLiteral("lit_gap_offx", int'(offsetX), 0);
    applyStimulus(100, 472, 0, 0, 0, 0);
    checkLiteral("lit_below_inside", int'(InsideRectangle), 0);
    checkLiteral("lit_below_offy", int'(offsetY), 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(bx[i], by[i], 0, 0, 0, 0);
      if (i == 1) begin
        checkLiteral("lit_corner_offx", int'(offsetX), 71);
        checkLiteral("lit_corner_offy", int'(offsetY), 71);
      end
    end

    applyStimulus(0, 0, 0, 1, 0, 0);
    checkLiteral("lit_extra_saturate", int'(livesCount), 3);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkLiteral("lit_hit_beats_extra", int'(livesCount), 2);

`ifdef LIFE_INVULN_EN
    for (int f = 0; f < 60; f++) begin
      applyStimulus(180, 400, 0, 0, 0, 0);
      checkLiteral("lit_blink_inside", int'(InsideRectangle), ((f / 8) % 2 == 0) ? 1 : 0);
      checkLiteral("lit_blink_offx", int'(offsetX), ((f / 8) % 2 == 0) ? 4 : 0);
      if (f == 5) begin
        applyStimulus(180, 400, 1, 0, 0, 0);
        checkLiteral("lit_hit_in_invuln", int'(livesCount), 2);
      end
      applyStimulus(180, 400, 0, 0, 0, 1);
    end
    for (int k = 0; k < 20; k++) begin
      applyStimulus(180, 400, 0, 0, 0, k % 2);
      checkLiteral("lit_after_invuln", int'(InsideRectangle), 0);
    end
`else
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkLiteral("lit_back_to_back", int'(livesCount), 1);
    for (int k = 0; k < 20; k++) begin
      applyStimulus((k % 2 == 0) ? 180 : 100, 400, 0, 0, 0, k % 2);
      checkLiteral("lit_no_blink", int'(InsideRectangle), 0);
    end
    applyStimulus(20, 400, 0, 0, 0, 0);
    checkLiteral("lit_icon0_drawn", int'(InsideRectangle), 1);
`endif

    applyStimulus(0, 0, 1, 0, 1, 0);
    checkLiteral("lit_newgame_beats_hit", int'(livesCount), 3);
    checkLiteral("lit_newgame_over", int'(gameOver), 0);

    applyStimulus(0, 0, 1, 0, 0, 0);
    runFrames(61);
    applyStimulus(0, 0, 1, 0, 0, 0);
    runFrames(61);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkLiteral("lit_dead_lives", int'(livesCount), 0);
    checkLiteral("lit_dead_over", int'(gameOver), 1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkLiteral("lit_dead_extra", int'(livesCount), 0);
    applyStimulus(20, 410, 1, 0, 0, 0);
    checkLiteral("lit_dead_inside", int'(InsideRectangle), 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkLiteral("lit_restart_lives", int'(livesCount), 3);
    checkLiteral("lit_restart_over", int'(gameOver), 0);

    applyStimulus(0, 0, 1, 0, 0, 0);
    applyStimulus(100, 410, 0, 0, 0, 0);
    @(negedge clk);
    #2 resetN = 1'b0;
    #1;
    modelReset();
    checkLiteral("lit_async_lives", int'(livesCount), 3);
    checkLiteral("lit_async_inside", int'(InsideRectangle), 0);
    checkLiteral("lit_async_offx", int'(offsetX), 0);
    checkLiteral("lit_async_offy", int'(offsetY), 0);
    checkLiteral("lit_async_over", int'(gameOver), 0);
    @(negedge clk);
    resetN = 1'b1;
    applyStimulus(100, 410, 0, 0, 0, 0);
    applyStimulus(180, 410, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
